// File: rtl/id_pipe.sv
// id_pipe: decode stage for a MIPS logic/shift subset with priority operand forwarding,
// load-use stall and a one-entry ID/EX register. Optional counter: ID_PIPE_ILLEGAL_CNT_EN.
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int FWD_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              inst_in,
    input  logic                     flush,
    output logic                     id_reg_re1,
    output logic                     id_reg_re2,
    output logic [4:0]               id_reg_ra1,
    output logic [4:0]               id_reg_ra2,
    input  logic [DATA_W-1:0]        reg_id_data1,
    input  logic [DATA_W-1:0]        reg_id_data2,
    input  logic [FWD_CH-1:0]        fwd_we,
    input  logic [FWD_CH-1:0]        fwd_load,
    input  logic [5*FWD_CH-1:0]      fwd_addr,
    input  logic [DATA_W*FWD_CH-1:0] fwd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               alu_op,
    output logic [2:0]               alu_sel,
    output logic [DATA_W-1:0]        id_src1,
    output logic [DATA_W-1:0]        id_src2,
    output logic [4:0]               id_des_addr,
    output logic                     id_des_exist,
    output logic [31:0]              pc_out,
    output logic                     inst_invalid
`ifdef ID_PIPE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]              illegal_cnt
`endif
);

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_XORI    = 6'b001110;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_PREF    = 6'b110011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SYNC = 6'b001111;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_AND = 8'h24;
    localparam logic [7:0] ALU_OR  = 8'h25;
    localparam logic [7:0] ALU_XOR = 8'h26;
    localparam logic [7:0] ALU_NOR = 8'h27;
    localparam logic [7:0] ALU_SLL = 8'h7C;
    localparam logic [7:0] ALU_SRL = 8'h02;
    localparam logic [7:0] ALU_SRA = 8'h03;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    typedef struct packed {
        logic [7:0]        alu_op;
        logic [2:0]        alu_sel;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [4:0]        des;
        logic              exist;
        logic [31:0]       pc;
        logic              invalid;
    } payload_t;

    // ALU op/select for SPECIAL-class function codes.
    function automatic logic [10:0] r_alu(input logic [5:0] funct);
        logic [10:0] res;
        case (funct)
            FN_OR:           res = {ALU_OR,  SEL_LOGIC};
            FN_AND:          res = {ALU_AND, SEL_LOGIC};
            FN_XOR:          res = {ALU_XOR, SEL_LOGIC};
            FN_NOR:          res = {ALU_NOR, SEL_LOGIC};
            FN_SLL, FN_SLLV: res = {ALU_SLL, SEL_SHIFT};
            FN_SRL, FN_SRLV: res = {ALU_SRL, SEL_SHIFT};
            FN_SRA, FN_SRAV: res = {ALU_SRA, SEL_SHIFT};
            default:         res = {ALU_NOP, SEL_NOP};
        endcase
        return res;
    endfunction

    // ALU op/select for the logic-immediate opcodes; lui is an OR against {imm,0}.
    function automatic logic [10:0] i_alu(input logic [5:0] opc);
        logic [10:0] res;
        case (opc)
            OPC_ORI, OPC_LUI: res = {ALU_OR,  SEL_LOGIC};
            OPC_ANDI:         res = {ALU_AND, SEL_LOGIC};
            OPC_XORI:         res = {ALU_XOR, SEL_LOGIC};
            default:          res = {ALU_NOP, SEL_NOP};
        endcase
        return res;
    endfunction

    // Returns {load_hit, value}. Walking from the oldest channel down lets channel 0 win.
    function automatic logic [DATA_W:0] pick_operand(
        input logic [4:0]               ra,
        input logic [DATA_W-1:0]        rf_data,
        input logic [FWD_CH-1:0]        we,
        input logic [FWD_CH-1:0]        ld,
        input logic [5*FWD_CH-1:0]      addr,
        input logic [DATA_W*FWD_CH-1:0] data
    );
        logic [DATA_W:0] res;
        res = {1'b0, rf_data};
        for (int i = FWD_CH - 1; i >= 0; i--) begin
            if (we[i] && (addr[i*5 +: 5] == ra)) begin
                res = {ld[i], data[i*DATA_W +: DATA_W]};
            end
        end
        if (ra == 5'd0) begin
            res = {(DATA_W + 1){1'b0}};
        end
        return res;
    endfunction

    logic [5:0] op_f;
    logic [4:0] rs_f, rt_f, rd_f, sa_f;
    logic [5:0] funct_f;
    logic [15:0] imm_f;

    assign op_f    = inst_in[31:26];
    assign rs_f    = inst_in[25:21];
    assign rt_f    = inst_in[20:16];
    assign rd_f    = inst_in[15:11];
    assign sa_f    = inst_in[10:6];
    assign funct_f = inst_in[5:0];
    assign imm_f   = inst_in[15:0];

    logic              re1_s, re2_s;
    logic [4:0]        ra1_s, ra2_s;
    logic [DATA_W-1:0] imm1_s, imm2_s;
    logic [7:0]        dop_s;
    logic [2:0]        dsel_s;
    logic [4:0]        ddes_s;
    logic              dexist_s;
    logic              dinvalid_s;

    // Instruction decode: read ports, immediates, destination and ALU controls.
    always_comb begin
        re1_s      = 1'b0;
        re2_s      = 1'b0;
        ra1_s      = 5'd0;
        ra2_s      = 5'd0;
        imm1_s     = {DATA_W{1'b0}};
        imm2_s     = {DATA_W{1'b0}};
        dop_s      = ALU_NOP;
        dsel_s     = SEL_NOP;
        ddes_s     = 5'd0;
        dexist_s   = 1'b0;
        dinvalid_s = 1'b1;
        case (op_f)
            OPC_SPECIAL: begin
                case (funct_f)
                    FN_OR, FN_AND, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        if (sa_f == 5'd0) begin
                            re1_s           = 1'b1;
                            ra1_s           = rs_f;
                            re2_s           = 1'b1;
                            ra2_s           = rt_f;
                            ddes_s          = rd_f;
                            dexist_s        = 1'b1;
                            dinvalid_s      = 1'b0;
                            {dop_s, dsel_s} = r_alu(funct_f);
                        end else begin
                            dinvalid_s = 1'b1;
                        end
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        if (rs_f == 5'd0) begin
                            re2_s           = 1'b1;
                            ra2_s           = rt_f;
                            imm1_s[4:0]     = sa_f;
                            ddes_s          = rd_f;
                            dexist_s        = 1'b1;
                            dinvalid_s      = 1'b0;
                            {dop_s, dsel_s} = r_alu(funct_f);
                        end else begin
                            dinvalid_s = 1'b1;
                        end
                    end
                    FN_SYNC: dinvalid_s = 1'b0;
                    default: dinvalid_s = 1'b1;
                endcase
            end
            OPC_ORI, OPC_ANDI, OPC_XORI: begin
                re1_s           = 1'b1;
                ra1_s           = rs_f;
                imm2_s[15:0]    = imm_f;
                ddes_s          = rt_f;
                dexist_s        = 1'b1;
                dinvalid_s      = 1'b0;
                {dop_s, dsel_s} = i_alu(op_f);
            end
            OPC_LUI: begin
                re1_s           = 1'b1;
                ra1_s           = rs_f;
                imm2_s[31:16]   = imm_f;
                ddes_s          = rt_f;
                dexist_s        = 1'b1;
                dinvalid_s      = 1'b0;
                {dop_s, dsel_s} = i_alu(op_f);
            end
            OPC_PREF: dinvalid_s = 1'b0;
            default:  dinvalid_s = 1'b1;
        endcase
    end

    logic [DATA_W:0]   pick1_s, pick2_s;
    logic [DATA_W-1:0] src1_s, src2_s;
    logic              stall_s;

    // Operand muxing and load-use detection on the enabled read ports.
    always_comb begin
        pick1_s = pick_operand(ra1_s, reg_id_data1, fwd_we, fwd_load, fwd_addr, fwd_data);
        pick2_s = pick_operand(ra2_s, reg_id_data2, fwd_we, fwd_load, fwd_addr, fwd_data);
        stall_s = (re1_s & pick1_s[DATA_W]) | (re2_s & pick2_s[DATA_W]);
        src1_s  = re1_s ? pick1_s[DATA_W-1:0] : imm1_s;
        src2_s  = re2_s ? pick2_s[DATA_W-1:0] : imm2_s;
    end

    assign id_reg_re1 = ~rst & re1_s;
    assign id_reg_re2 = ~rst & re2_s;
    assign id_reg_ra1 = rst ? 5'd0 : ra1_s;
    assign id_reg_ra2 = rst ? 5'd0 : ra2_s;

    logic     valid_q, valid_d;
    payload_t payload_q, payload_d;
    payload_t dec_payload_s;
    logic     accept_s;

    assign in_ready = ~stall_s & (~valid_q | out_ready);
    assign accept_s = in_valid & in_ready & ~flush;

    assign dec_payload_s = '{alu_op:  dop_s,
                             alu_sel: dsel_s,
                             src1:    src1_s,
                             src2:    src2_s,
                             des:     ddes_s,
                             exist:   dexist_s,
                             pc:      pc_in,
                             invalid: dinvalid_s};

    // ID/EX next state: flush beats accept, accept beats drain, otherwise hold.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (flush) begin
            valid_d   = 1'b0;
            payload_d = '0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            payload_d = dec_payload_s;
        end else if (out_ready) begin
            valid_d   = 1'b0;
            payload_d = '0;
        end else begin
            valid_d   = valid_q;
            payload_d = payload_q;
        end
    end

    // ID/EX register; an all-zero payload encodes the nop controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid    = valid_q;
    assign alu_op       = payload_q.alu_op;
    assign alu_sel      = payload_q.alu_sel;
    assign id_src1      = payload_q.src1;
    assign id_src2      = payload_q.src2;
    assign id_des_addr  = payload_q.des;
    assign id_des_exist = payload_q.exist;
    assign pc_out       = payload_q.pc;
    assign inst_invalid = payload_q.invalid;

`ifdef ID_PIPE_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of accepted invalid instructions.
    always_comb begin
        if (accept_s && dinvalid_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: per-scenario tasks plus a queue scoreboard
// that compares the ID/EX payload every cycle against expected entries.
module tb_id_pipe;
    localparam int DATA_W = 32;
    localparam int FWD_CH = 2;

    localparam logic [7:0] A_NOP = 8'h00, A_AND = 8'h24, A_OR  = 8'h25, A_XOR = 8'h26;
    localparam logic [7:0] A_NOR = 8'h27, A_SLL = 8'h7C, A_SRL = 8'h02, A_SRA = 8'h03;
    localparam logic [2:0] S_NOP = 3'b000, S_LOGIC = 3'b001, S_SHIFT = 3'b010;
    localparam logic [31:0] RD1 = 32'h1111_1111;
    localparam logic [31:0] RD2 = 32'h2222_2222;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              pc_in;
    logic [31:0]              inst_in;
    logic                     flush;
    logic                     id_reg_re1, id_reg_re2;
    logic [4:0]               id_reg_ra1, id_reg_ra2;
    logic [DATA_W-1:0]        reg_id_data1, reg_id_data2;
    logic [FWD_CH-1:0]        fwd_we, fwd_load;
    logic [5*FWD_CH-1:0]      fwd_addr;
    logic [DATA_W*FWD_CH-1:0] fwd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               alu_op;
    logic [2:0]               alu_sel;
    logic [DATA_W-1:0]        id_src1, id_src2;
    logic [4:0]               id_des_addr;
    logic                     id_des_exist;
    logic [31:0]              pc_out;
    logic                     inst_invalid;
`ifdef ID_PIPE_ILLEGAL_CNT_EN
    logic [15:0]              illegal_cnt;
`endif

    id_pipe #(.DATA_W(DATA_W), .FWD_CH(FWD_CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .flush        (flush),
        .id_reg_re1   (id_reg_re1),
        .id_reg_re2   (id_reg_re2),
        .id_reg_ra1   (id_reg_ra1),
        .id_reg_ra2   (id_reg_ra2),
        .reg_id_data1 (reg_id_data1),
        .reg_id_data2 (reg_id_data2),
        .fwd_we       (fwd_we),
        .fwd_load     (fwd_load),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_op       (alu_op),
        .alu_sel      (alu_sel),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_des_addr  (id_des_addr),
        .id_des_exist (id_des_exist),
        .pc_out       (pc_out),
        .inst_invalid (inst_invalid)
`ifdef ID_PIPE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt  (illegal_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [113:0] exp_q[$];
    logic [113:0] act_s;
    logic         prev_valid = 1'b0;
    bit           mon_en = 1'b0;

    assign act_s = {alu_op, alu_sel, id_src1, id_src2, id_des_addr, id_des_exist, pc_out, inst_invalid};

    // Scoreboard: retire the entry consumed/killed at the last edge, then compare the current one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_valid && (out_ready || flush || rst) && exp_q.size() > 0)
                void'(exp_q.pop_front());
            checks++;
            if (out_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL sb_out_valid actual=%b expected=%b t=%0t", out_valid, exp_q.size() != 0, $time);
            end else if (out_valid) begin
                checks++;
                if (act_s !== exp_q[0]) begin
                    failures++;
                    $display("FAIL sb_payload actual=%h expected=%h t=%0t", act_s, exp_q[0], $time);
                end
            end else begin
                checks++;
                if ({alu_op, alu_sel, id_des_exist} !== {A_NOP, S_NOP, 1'b0}) begin
                    failures++;
                    $display("FAIL sb_idle_nop actual=%h/%h/%b expected=00/0/0 t=%0t", alu_op, alu_sel, id_des_exist, $time);
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        in_valid  = v;
        inst_in   = inst;
        pc_in     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic set_fwd(input logic [1:0] we, input logic [1:0] ld, input logic [4:0] a1,
                           input logic [4:0] a0, input logic [31:0] d1, input logic [31:0] d0);
        fwd_we   = we;
        fwd_load = ld;
        fwd_addr = {a1, a0};
        fwd_data = {d1, d0};
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [7:0] op,
                         input logic [2:0] sel, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] des, input logic ex, input logic inv);
        drive(1'b1, inst, pc, 1'b1, 1'b0);
        exp_q.push_back({op, sel, s1, s2, des, ex, pc, inv});
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; inst_in = 32'h3401_1234; pc_in = 32'h0000_0100;
        flush = 1'b0; out_ready = 1'b1; set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        reg_id_data1 = RD1; reg_id_data2 = RD2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({id_reg_re1, id_reg_re2, id_reg_ra1, id_reg_ra2} !== 12'd0) begin
            failures++;
            $display("FAIL rst_read_ctrl actual=%b%b/%0d/%0d expected=00/0/0", id_reg_re1, id_reg_re2, id_reg_ra1, id_reg_ra2);
        end
        checks++;
        if ({out_valid, act_s} !== 115'd0) begin
            failures++;
            $display("FAIL rst_outputs actual=%b/%h expected=0/0", out_valid, act_s);
        end
`ifdef ID_PIPE_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_cnt actual=%0d expected=0", illegal_cnt);
        end
`endif
        @(negedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({id_reg_re1, id_reg_re2} !== 2'b10) begin
            failures++;
            $display("FAIL post_rst_re actual=%b%b expected=10", id_reg_re1, id_reg_re2);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_decode;
        issue(32'h3401_1234, 32'h100, A_OR,  S_LOGIC, 32'd0, 32'h0000_1234, 5'd1,  1'b1, 1'b0);
        issue(32'h0022_1825, 32'h104, A_OR,  S_LOGIC, RD1,   RD2,           5'd3,  1'b1, 1'b0);
        issue(32'h0003_1100, 32'h108, A_SLL, S_SHIFT, 32'd4, RD2,           5'd2,  1'b1, 1'b0);
        issue(32'h3C07_ABCD, 32'h10C, A_OR,  S_LOGIC, 32'd0, 32'hABCD_0000, 5'd7,  1'b1, 1'b0);
        issue(32'h38C5_00F0, 32'h110, A_XOR, S_LOGIC, RD1,   32'h0000_00F0, 5'd5,  1'b1, 1'b0);
        issue(32'h0022_1865, 32'h114, A_NOP, S_NOP,   32'd0, 32'd0,         5'd0,  1'b0, 1'b1);
        issue(32'h0000_000F, 32'h118, A_NOP, S_NOP,   32'd0, 32'd0,         5'd0,  1'b0, 1'b0);
        issue(32'h0022_4027, 32'h11C, A_NOR, S_LOGIC, RD1,   RD2,           5'd8,  1'b1, 1'b0);
        issue(32'h0022_4807, 32'h120, A_SRA, S_SHIFT, RD1,   RD2,           5'd9,  1'b1, 1'b0);
        issue(32'h302A_FFFF, 32'h124, A_AND, S_LOGIC, RD1,   32'h0000_FFFF, 5'd10, 1'b1, 1'b0);
        issue(32'hCC00_0000, 32'h128, A_NOP, S_NOP,   32'd0, 32'd0,         5'd0,  1'b0, 1'b0);
        issue(32'h0002_5FC3, 32'h12C, A_SRA, S_SHIFT, 32'd31, RD2,          5'd11, 1'b1, 1'b0);
        issue(32'h0023_1100, 32'h130, A_NOP, S_NOP,   32'd0, 32'd0,         5'd0,  1'b0, 1'b1);
        issue(32'h0022_1826, 32'h134, A_XOR, S_LOGIC, RD1,   RD2,           5'd3,  1'b1, 1'b0);
        issue(32'h0022_1806, 32'h138, A_SRL, S_SHIFT, RD1,   RD2,           5'd3,  1'b1, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_forward;
        issue(32'h0022_1825, 32'h200, A_OR, S_LOGIC, 32'hA, RD2, 5'd3, 1'b1, 1'b0);
        set_fwd(2'b11, 2'b00, 5'd1, 5'd1, 32'hB, 32'hA);
        #1;
        checks++;
        if ({id_reg_re1, id_reg_ra1, id_reg_re2, id_reg_ra2} !== {1'b1, 5'd1, 1'b1, 5'd2}) begin
            failures++;
            $display("FAIL fwd_read_ctrl actual=%b/%0d/%b/%0d expected=1/1/1/2", id_reg_re1, id_reg_ra1, id_reg_re2, id_reg_ra2);
        end
        issue(32'h0022_1825, 32'h204, A_OR, S_LOGIC, 32'hB, RD2, 5'd3, 1'b1, 1'b0);
        set_fwd(2'b10, 2'b00, 5'd1, 5'd1, 32'hB, 32'hA);
        issue(32'h0022_1825, 32'h208, A_OR, S_LOGIC, 32'hB, 32'h77, 5'd3, 1'b1, 1'b0);
        set_fwd(2'b11, 2'b00, 5'd1, 5'd2, 32'hB, 32'h77);
        issue(32'h0000_0825, 32'h20C, A_OR, S_LOGIC, 32'd0, 32'd0, 5'd1, 1'b1, 1'b0);
        set_fwd(2'b01, 2'b01, 5'd0, 5'd0, 32'd0, 32'h0000_FFFF);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_r0_no_stall actual=%b expected=1", in_ready);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_stall;
        issue(32'h3401_1234, 32'h300, A_OR, S_LOGIC, 32'd0, 32'h0000_1234, 5'd1, 1'b1, 1'b0);
        drive(1'b1, 32'h0045_2024, 32'h304, 1'b1, 1'b0);
        set_fwd(2'b01, 2'b01, 5'd0, 5'd2, 32'd0, 32'h55);
        #1;
        checks++;
        if ({in_ready, id_reg_re1, id_reg_ra1} !== {1'b0, 1'b1, 5'd2}) begin
            failures++;
            $display("FAIL stall_in_ready actual=%b/%b/%0d expected=0/1/2", in_ready, id_reg_re1, id_reg_ra1);
        end
        drive(1'b1, 32'h0045_2024, 32'h304, 1'b1, 1'b0);
        set_fwd(2'b01, 2'b00, 5'd0, 5'd2, 32'd0, 32'h55);
        exp_q.push_back({A_AND, S_LOGIC, 32'h55, RD2, 5'd4, 1'b1, 32'h304, 1'b0});
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL stall_bubble actual=%b%b expected=10", in_ready, out_valid);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        set_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_hold_flush;
        logic [113:0] snap;
        issue(32'h38C5_00F0, 32'h400, A_XOR, S_LOGIC, RD1, 32'h0000_00F0, 5'd5, 1'b1, 1'b0);
        snap = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0022_1825, 32'h404, 1'b0, 1'b0);
            #1;
            if (i == 0) snap = act_s;
            checks++;
            if ({in_ready, out_valid} !== 2'b01) begin
                failures++;
                $display("FAIL hold_ready actual=%b%b expected=01 cycle=%0d", in_ready, out_valid, i);
            end
        end
        checks++;
        if (act_s !== snap) begin
            failures++;
            $display("FAIL hold_stable actual=%h expected=%h", act_s, snap);
        end
        drive(1'b1, 32'h0022_1825, 32'h408, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if ({out_valid, pc_out} !== {1'b0, 32'd0}) begin
            failures++;
            $display("FAIL hold_flush actual=%b/%h expected=0/00000000", out_valid, pc_out);
        end
        drive(1'b1, 32'h3401_1234, 32'h40C, 1'b1, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_in_ready actual=%b expected=1", in_ready);
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_accept actual=%b expected=0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        issue(32'h3401_1234, 32'h500, A_OR, S_LOGIC, 32'd0, 32'h0000_1234, 5'd1, 1'b1, 1'b0);
        drive(1'b1, 32'h0022_1825, 32'h504, 1'b0, 1'b0);
        drive(1'b1, 32'h0022_1825, 32'h508, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, pc_out, alu_op} !== {1'b0, 32'd0, A_NOP}) begin
            failures++;
            $display("FAIL rst_mid_discard actual=%b/%h/%h expected=0/00000000/00", out_valid, pc_out, alu_op);
        end
    endtask

    task automatic test_illegal;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
`ifdef ID_PIPE_ILLEGAL_CNT_EN
        #1;
        checks++;
        if (illegal_cnt !== 16'd0) begin
            failures++;
            $display("FAIL cnt_cleared actual=%0d expected=0", illegal_cnt);
        end
`endif
        issue(32'hFC00_0000, 32'h600, A_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        issue(32'hFC00_0000, 32'h604, A_NOP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
`ifdef ID_PIPE_ILLEGAL_CNT_EN
        #1;
        checks++;
        if (illegal_cnt !== 16'd2) begin
            failures++;
            $display("FAIL cnt_two actual=%0d expected=2", illegal_cnt);
        end
`endif
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        rst = 1'b0;
`ifdef ID_PIPE_ILLEGAL_CNT_EN
        #1;
        checks++;
        if (illegal_cnt !== 16'd0) begin
            failures++;
            $display("FAIL cnt_rst actual=%0d expected=0", illegal_cnt);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_decode;
        test_forward;
        test_stall;
        test_hold_flush;
        test_reset_mid;
        test_illegal;
        repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
